load_store_unit: RTL and testbench

//  Byte-addressed load/store front end placed directly upstream of data_memory (word-addressed, 1-cycle registered read).

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_store_unit_lane.sv | 49 ++++
 rtl/load_store_unit.sv | 120 ++++++++++++
 tb/tb_load_store_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM encoding and request-check helpers for the LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } lsu_state_e;

  function automatic logic f3_bad(
    input logic       wr,
    input logic [2:0] f3
  );
    logic ok_st;
    ok_st = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (wr) return !ok_st;
    return !(ok_st || (f3 == F3_BU) || (f3 == F3_HU));
  endfunction

  function automatic logic misal(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    if ((f3 == F3_H) || (f3 == F3_HU)) return a[0];
    if (f3 == F3_W) return |a;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte-lane datapath: sub-word load extract/extend and SB/SH store merge.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_f3,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [15:0] w_sh;
  logic [4:0]  w_boff;
  logic [4:0]  w_hoff;
  logic [31:0] w_bmask;
  logic [31:0] w_hmask;

  assign w_boff  = {i_lane, 3'b000};
  assign w_hoff  = {i_lane[1], 4'b0000};
  assign w_sh    = 16'(i_word >> w_boff);
  assign w_bmask = 32'h0000_00ff << w_boff;
  assign w_hmask = 32'h0000_ffff << w_hoff;

  always_comb begin
    o_load = i_word;
    unique case (1'b1)
      (i_f3 == F3_B):  o_load = {{24{w_sh[7]}}, w_sh[7:0]};
      (i_f3 == F3_BU): o_load = {24'd0, w_sh[7:0]};
      (i_f3 == F3_H):  o_load = {{16{w_sh[15]}}, w_sh};
      (i_f3 == F3_HU): o_load = {16'd0, w_sh};
      default:         o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    unique case (1'b1)
      (i_f3 == F3_B):
        o_merged = (i_word & ~w_bmask)
                 | ({24'd0, i_wdata[7:0]} << w_boff);
      (i_f3 == F3_H):
        o_merged = (i_word & ~w_hmask)
                 | ({16'd0, i_wdata} << w_hoff);
      default: o_merged = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed LSU in front of a word-addressed, 1-cycle-read data memory.
// Build option: LSU_BOUNDS_CHECK_EN makes addresses beyond the memory an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  lsu_state_e        r_state;
  logic              r_write;
  logic [2:0]        r_f3;
  logic [IDX_W+1:0]  r_addr;
  logic [31:0]       r_wdata;

  logic              w_oob;
  logic              w_err;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

`ifdef LSU_BOUNDS_CHECK_EN
  assign w_oob = (req_addr >= 32'(MEM_DEPTH * 4));
`else
  // high address bits are dropped so the word index wraps
  assign w_oob = 1'b0 & (|req_addr[31:IDX_W+2]);
`endif

  assign w_err = f3_bad(req_write, req_funct3)
               | misal(req_funct3, req_addr[1:0])
               | w_oob;

  lsu_byte_lane u_lane (
    .i_word   (mem_read_data),
    .i_lane   (r_addr[1:0]),
    .i_f3     (r_f3),
    .i_wdata  (r_wdata[15:0]),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  assign req_ready      = (r_state == S_IDLE);
  assign mem_address    = {{(32-IDX_W){1'b0}}, r_addr[IDX_W+1:2]};
  assign mem_write_data = (r_f3 == F3_W) ? r_wdata : w_merged;
  assign resp_rdata     = (r_state == S_RESP && !r_write && !resp_error)
                        ? w_load : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_write          <= 1'b0;
      r_f3             <= '0;
      r_addr           <= '0;
      r_wdata          <= '0;
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
    end else begin
      resp_valid       <= 1'b0;
      resp_error       <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_f3    <= req_funct3;
            r_addr  <= req_addr[IDX_W+1:0];
            r_wdata <= req_wdata;
            if (w_err) begin
              r_state    <= S_RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else if (req_write && req_funct3 == F3_W) begin
              r_state          <= S_WR;
              mem_write_enable <= 1'b1;
            end else begin
              r_state         <= S_RD;
              mem_read_enable <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (r_write) begin
            r_state          <= S_WR;
            mem_write_enable <= 1'b1;
          end else begin
            r_state    <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_WR: begin
          r_state    <= S_RESP;
          resp_valid <= 1'b1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1-cycle data memory.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem [1024];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(1024)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_error       (resp_error),
    .resp_rdata       (resp_rdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[9:0]] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= mem[mem_address[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        err, got, en_seen, both;
    int          lat;
    rd = 'x; err = 1'bx; got = 0; en_seen = 0; both = 0;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      if (mem_read_enable || mem_write_enable) en_seen = 1;
      if (mem_read_enable && mem_write_enable) both = 1;
      if (resp_valid) begin
        got = 1; rd = resp_rdata; err = resp_error;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".resp_seen"}, 32'(got), 32'd1);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".error"}, 32'(err), 32'(exp_err));
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".both_en"}, 32'(both), 32'd0);
    if (exp_err) chk({tag, ".no_mem_en"}, 32'(en_seen), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".pulse_1cyc"}, 32'(resp_valid), 32'd0);
    chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0;
    req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_error", 32'(resp_error), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.re", 32'(mem_read_enable), 32'd0);
    chk("rst.we", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    rst_n = 1;

    run("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
    run("lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);

    run("sw20", 1, 3'b010, 32'h20, 32'h80F17F22, 32'h0, 0, 2);
    run("lb21", 0, 3'b000, 32'h21, 32'h0, 32'h0000007F, 0, 2);
    run("lb23", 0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 0, 2);
    run("lbu23", 0, 3'b100, 32'h23, 32'h0, 32'h00000080, 0, 2);
    run("lh22", 0, 3'b001, 32'h22, 32'h0, 32'hFFFF80F1, 0, 2);
    run("lhu20", 0, 3'b101, 32'h20, 32'h0, 32'h00007F22, 0, 2);

    run("sw30", 1, 3'b010, 32'h30, 32'h11223344, 32'h0, 0, 2);
    run("sb31", 1, 3'b000, 32'h31, 32'h000000AA, 32'h0, 0, 3);
    run("lw30a", 0, 3'b010, 32'h30, 32'h0, 32'h1122AA44, 0, 2);
    run("sh32", 1, 3'b001, 32'h32, 32'hFFFF5566, 32'h0, 0, 3);
    run("lw30b", 0, 3'b010, 32'h30, 32'h0, 32'h5566AA44, 0, 2);

    run("sw40", 1, 3'b010, 32'h40, 32'h01020304, 32'h0, 0, 2);
    run("lw06", 0, 3'b010, 32'h06, 32'h0, 32'h0, 1, 1);
    run("sh41", 1, 3'b001, 32'h41, 32'hFFFF, 32'h0, 1, 1);
    run("st_f3", 1, 3'b100, 32'h40, 32'hFF, 32'h0, 1, 1);
    run("ld_f3", 0, 3'b011, 32'h40, 32'h0, 32'h0, 1, 1);
    chk("mem40_kept", mem[16], 32'h01020304);

    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'b000;
    req_addr = 32'h31; req_wdata = 32'hBB;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rmwrst.in_rd", 32'(mem_read_enable), 32'd1);
    rst_n = 0;
    #1;
    chk("rmwrst.we_low", 32'(mem_write_enable), 32'd0);
    chk("rmwrst.no_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rmwrst.ready", 32'(req_ready), 32'd1);
    chk("rmwrst.no_resp2", 32'(resp_valid), 32'd0);
    chk("rmwrst.mem", mem[12], 32'h5566AA44);
    run("lw30c", 0, 3'b010, 32'h30, 32'h0, 32'h5566AA44, 0, 2);

`ifdef LSU_BOUNDS_CHECK_EN
    run("sw1000", 1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 1, 1);
`else
    run("sw1000", 1, 3'b010, 32'h1000, 32'hCAFEF00D, 32'h0, 0, 2);
    run("lw0", 0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0, 2);
    chk("mem0", mem[0], 32'hCAFEF00D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
